soc_multi_sp_ram: RTL and testbench
===================================

# soc_multi_sp_ram

Top-level dual-core SoC used for redundant-execution experiments. Two identical RISC-V cores run the same program in lockstep from a shared single-port instruction RAM and a shared single-port data RAM. Core 0 is the master and owns the memory ports; core 1 is a shadow whose requests are only compared. Data RAM words 0 and 1 are exported as a completion flag and a result.

## Interface
Parameters:
- MEM_WORDS, 256: depth of each RAM in 32-bit words.
- BOOT_ADDR, 32'h0000_0000: reset fetch address of both cores.

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, asynchronous and active-low.
- fetch_enable_i  in  1  fetch enable, driven to both cores.
- mem_flag_o  out  32  data RAM word 0, continuous read.
- mem_result_o  out  32  data RAM word 1, continuous read.
- instr_addr_o_0  out  32  core 0 instruction fetch address.

## Operation
- Instances: u_core0, u_core1 (existing core), inst_mem, data_mem (sp_ram). Each RAM exposes its storage array as `mem` so benches can preload it hierarchically (inst_mem via $readmemb).
- Each core's instr_fetch_err input is tied to 0 inside the SoC.
- Instruction bus (Harvard, base 0): core 0 req/addr drive inst_mem. The grant and rdata are broadcast to both cores.
- Data bus (base 0): core 0 req/we/be/addr/wdata drive data_mem. Grant, rvalid and rdata are broadcast to both cores. Core 1 never writes memory.
- Lockstep check: whenever either core's instr or data req is high, compare core 0 and core 1 req/addr/we/be/wdata. Any mismatch sets the sticky internal register lockstep_err_q. It clears only on reset and has no effect on execution.
- RAM word index is addr[9:2]. If addr[31:10] != 0: writes are dropped, reads return 0, and the access is still granted.
- Byte enables apply per byte on writes.
- mem_flag_o = data_mem.mem[0] and mem_result_o = data_mem.mem[1], both combinational. These outputs are not affected by reset; RAM contents are never reset.
- instr_addr_o_0 is driven directly from core 0's instr_addr_o.

## Timing
- Handshake: gnt is asserted in the same cycle as req (no wait states). rvalid and rdata follow exactly 1 cycle after the grant, for reads and writes alike. Reads are synchronous, so one access per cycle is sustained.
- A write is visible on mem_flag_o/mem_result_o in the cycle after its grant edge.
- While rst_ni is low, both cores are held in reset and instr_addr_o_0 = BOOT_ADDR.
- Fetching starts on the first rising edge with rst_ni=1 and fetch_enable_i=1.
- fetch_enable_i low: the cores issue no new fetches and the memories idle.
- Reset asserted mid-access: the pending rvalid is killed asynchronously. RAM contents are preserved.

## Structure
- Shared package soc_pkg: MEM_WORDS, BOOT_ADDR, address-decode constants (word index bits, out-of-range mask), and a bus request struct {req, we, be, addr, wdata} used by the lockstep comparator.
- One natural sub-module, sp_ram: single-port synchronous RAM with req/we/be/addr/wdata/gnt/rvalid/rdata. It is instantiated twice.
- The comparator stays inline in the SoC.

## Test plan
- Reset and idle: rst_ni=0 for 20 ns, fetch_enable_i=0 -> instr_addr_o_0=0x0 and no RAM writes.
- Store program: `li t0,42; sw t0,4(x0); li t0,1; sw t0,0(x0); loop` -> mem_result_o=42, then mem_flag_o=1. The flag must never rise before the result is written, and completion must occur well under 1000 ns at a 10 ns clock.
- Fibonacci preload: fibonacci_byte.bin with unused words set to X -> mem_flag_o becomes nonzero and mem_result_o equals the golden-model Fibonacci value. instr_addr_o_0 must advance from 0x0 by 4 on sequential fetches.
- Byte-enable write: `sb` of 0xAB to address 5 over prior 0 -> mem_result_o=0x0000AB00.
- Out-of-range store to 0x0000_1000 -> all RAM words unchanged, core does not stall, lockstep_err_q stays 0.
- Forced divergence: force a core 1 data wdata bit for one cycle -> lockstep_err_q=1 and it stays 1 until rst_ni is pulsed. Memory results are unchanged.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared constants, bus request struct and small helpers for the lockstep dual-core SoC.
package soc_pkg;

  localparam int unsigned MEM_WORDS     = 256;
  localparam logic [31:0] BOOT_ADDR     = 32'h0000_0000;
  localparam int unsigned WORD_IDX_LSB  = 2;
  localparam int unsigned WORD_IDX_W    = 8;
  localparam logic [31:0] ADDR_OOR_MASK = 32'hFFFF_FC00;
  localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  typedef enum logic [1:0] {S_FETCH, S_IWAIT, S_EXEC, S_DWAIT} core_state_e;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'h37,
    OPC_AUIPC  = 7'h17,
    OPC_JAL    = 7'h6F,
    OPC_JALR   = 7'h67,
    OPC_BRANCH = 7'h63,
    OPC_LOAD   = 7'h03,
    OPC_STORE  = 7'h23,
    OPC_OP_IMM = 7'h13,
    OPC_OP     = 7'h33
  } opcode_e;

  // RV32I integer ALU; alt selects SUB / SRA.
  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op, input logic alt);
    logic [31:0] r;
    case (op)
      3'b000:  r = alt ? a - b : a + b;
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'b0, $signed(a) < $signed(b)};
      3'b011:  r = {31'b0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_core.sv
// Minimal multicycle RV32I core (fetch / wait / execute / data wait) with OBI-style buses.
module riscv_core
  import soc_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = soc_pkg::BOOT_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_enable,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_gnt,
  input  logic        instr_rvalid,
  input  logic [31:0] instr_rdata,
  input  logic        instr_fetch_err,
  output logic        data_req,
  output logic        data_we,
  output logic [3:0]  data_be,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_gnt,
  input  logic        data_rvalid,
  input  logic [31:0] data_rdata
);

  core_state_e state_q, state_d;
  logic [31:0] pc, ir;
  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_out, wb_val, pc_next, mem_addr;
  logic        wb_en, is_load, is_store, is_mem, taken, alt;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u  = {ir[31:12], 12'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'h0 : rf[rs2];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_mem   = is_load || is_store;
  assign mem_addr = rs1_val + (is_store ? imm_s : imm_i);
  assign alt      = ir[30] && ((opcode == OPC_OP) || (opcode == OPC_OP_IMM && f3 == 3'b101));
  assign alu_out  = alu(rs1_val, (opcode == OPC_OP) ? rs2_val : imm_i, f3, alt);

  always_comb begin
    case (f3)
      3'b000:  taken = (rs1_val == rs2_val);
      3'b001:  taken = (rs1_val != rs2_val);
      3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  taken = (rs1_val <  rs2_val);
      3'b111:  taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    pc_next = pc + 32'd4;
    wb_en   = 1'b0;
    wb_val  = alu_out;
    case (opcode)
      OPC_LUI:    begin wb_en = 1'b1; wb_val = imm_u; end
      OPC_AUIPC:  begin wb_en = 1'b1; wb_val = pc + imm_u; end
      OPC_JAL:    begin wb_en = 1'b1; wb_val = pc + 32'd4; pc_next = pc + imm_j; end
      OPC_JALR:   begin wb_en = 1'b1; wb_val = pc + 32'd4; pc_next = (rs1_val + imm_i) & ~32'd1; end
      OPC_BRANCH: if (taken) pc_next = pc + imm_b;
      OPC_OP, OPC_OP_IMM: wb_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (instr_req && instr_gnt) state_d = S_IWAIT;
      S_IWAIT: if (instr_rvalid)           state_d = S_EXEC;
      S_EXEC:  if (!is_mem)                state_d = S_FETCH;
               else if (data_gnt)          state_d = S_DWAIT;
      S_DWAIT: if (data_rvalid)            state_d = S_FETCH;
      default:                             state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instr_req  = (state_q == S_FETCH) && fetch_enable;
    instr_addr = pc;
    data_req   = (state_q == S_EXEC) && is_mem;
    data_we    = is_store;
    data_addr  = mem_addr;
    data_wdata = rs2_val << {mem_addr[1:0], 3'b000};
    case (f3[1:0])
      2'b00:   data_be = is_store ? (4'b0001 << mem_addr[1:0]) : 4'hF;
      2'b01:   data_be = is_store ? (4'b0011 << {mem_addr[1], 1'b0}) : 4'hF;
      default: data_be = 4'hF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= BOOT_ADDR;
      ir <= INSTR_NOP;
    end else begin
      if (state_q == S_IWAIT && instr_rvalid) ir <= instr_fetch_err ? INSTR_NOP : instr_rdata;
      if (state_q == S_EXEC && !is_mem)       pc <= pc_next;
      if (state_q == S_DWAIT && data_rvalid)  pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_EXEC && !is_mem && wb_en && rd != 5'd0) rf[rd] <= wb_val;
    if (state_q == S_DWAIT && data_rvalid && is_load && rd != 5'd0) rf[rd] <= data_rdata;
  end

endmodule

// File: rtl/sp_ram.sv
// Single-port synchronous RAM: zero-wait grant, rvalid/rdata one cycle after the grant.
module sp_ram
  import soc_pkg::*;
#(
  parameter int unsigned WORDS = soc_pkg::MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [29:0] addr,
  input  logic [31:0] wdata,
  output logic        gnt,
  output logic        rvalid,
  output logic [31:0] rdata
);

  logic [31:0]           mem [WORDS];
  logic                  in_range;
  logic [WORD_IDX_W-1:0] idx;

  assign gnt      = req;
  assign in_range = (({addr, 2'b00} & ADDR_OOR_MASK) == 32'h0);
  assign idx      = addr[WORD_IDX_W-1:0];

  // NOTE: storage has no reset; contents must survive rst_n and a reset loop would block RAM inference.
  always_ff @(posedge clk) begin
    if (req && we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req) rdata <= in_range ? mem[idx] : 32'h0;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid <= 1'b0;
    else        rvalid <= req;
  end

endmodule

// File: rtl/soc_multi_sp_ram.sv
// Dual-core lockstep SoC: core 0 owns both RAM ports, core 1 shadows and is compared every request.
module soc_multi_sp_ram
  import soc_pkg::*;
#(
  parameter int unsigned MEM_WORDS = soc_pkg::MEM_WORDS,
  parameter logic [31:0] BOOT_ADDR = soc_pkg::BOOT_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  output logic [31:0] mem_flag_o,
  output logic [31:0] mem_result_o,
  output logic [31:0] instr_addr_o_0
);

  logic        c0_instr_req, c1_instr_req, c0_data_req, c1_data_req;
  logic        c0_data_we, c1_data_we;
  logic [3:0]  c0_data_be, c1_data_be;
  logic [31:0] c0_instr_addr, c1_instr_addr, c0_data_addr, c1_data_addr;
  logic [31:0] c0_data_wdata, c1_data_wdata;
  logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid;
  logic [31:0] instr_rdata, data_rdata;
  bus_req_t    i0, i1, d0, d1;
  logic        lockstep_mismatch, lockstep_err_q;

  riscv_core #(.BOOT_ADDR(BOOT_ADDR)) u_core0 (
    .clk(clk_i), .rst_n(rst_ni), .fetch_enable(fetch_enable_i),
    .instr_req(c0_instr_req), .instr_addr(c0_instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .instr_fetch_err(1'b0),
    .data_req(c0_data_req), .data_we(c0_data_we), .data_be(c0_data_be),
    .data_addr(c0_data_addr), .data_wdata(c0_data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata)
  );

  riscv_core #(.BOOT_ADDR(BOOT_ADDR)) u_core1 (
    .clk(clk_i), .rst_n(rst_ni), .fetch_enable(fetch_enable_i),
    .instr_req(c1_instr_req), .instr_addr(c1_instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .instr_fetch_err(1'b0),
    .data_req(c1_data_req), .data_we(c1_data_we), .data_be(c1_data_be),
    .data_addr(c1_data_addr), .data_wdata(c1_data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata)
  );

  sp_ram #(.WORDS(MEM_WORDS)) inst_mem (
    .clk(clk_i), .rst_n(rst_ni), .req(c0_instr_req), .we(1'b0), .be(4'h0),
    .addr(c0_instr_addr[31:WORD_IDX_LSB]), .wdata(32'h0),
    .gnt(instr_gnt), .rvalid(instr_rvalid), .rdata(instr_rdata)
  );

  sp_ram #(.WORDS(MEM_WORDS)) data_mem (
    .clk(clk_i), .rst_n(rst_ni), .req(c0_data_req), .we(c0_data_we), .be(c0_data_be),
    .addr(c0_data_addr[31:WORD_IDX_LSB]), .wdata(c0_data_wdata),
    .gnt(data_gnt), .rvalid(data_rvalid), .rdata(data_rdata)
  );

  assign mem_flag_o     = data_mem.mem[0];
  assign mem_result_o   = data_mem.mem[1];
  assign instr_addr_o_0 = c0_instr_addr;

  assign i0 = '{req: c0_instr_req, we: 1'b0, be: 4'h0, addr: c0_instr_addr, wdata: 32'h0};
  assign i1 = '{req: c1_instr_req, we: 1'b0, be: 4'h0, addr: c1_instr_addr, wdata: 32'h0};
  assign d0 = '{req: c0_data_req, we: c0_data_we, be: c0_data_be, addr: c0_data_addr, wdata: c0_data_wdata};
  assign d1 = '{req: c1_data_req, we: c1_data_we, be: c1_data_be, addr: c1_data_addr, wdata: c1_data_wdata};

  // Only cycles with an active request on a bus are compared; idle bus fields are don't-care.
  assign lockstep_mismatch = ((i0.req || i1.req) && (i0 != i1)) ||
                             ((d0.req || d1.req) && (d0 != d1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                lockstep_err_q <= 1'b0;
    else if (lockstep_mismatch) lockstep_err_q <= 1'b1;
  end

endmodule

// File: tb/tb_soc_multi_sp_ram.sv
// Directed bench for soc_multi_sp_ram: hand-assembled programs, hand-computed RAM results.
module tb_soc_multi_sp_ram;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        fetch_enable_i;
  logic [31:0] mem_flag_o, mem_result_o, instr_addr_o_0;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] prog  [$];
  logic [31:0] addrs [$];
  time         t_start;
  logic        early;
  int          cyc;
  logic [31:0] bad_wdata;

  soc_multi_sp_ram dut (
    .clk_i(clk), .rst_ni(rst_ni), .fetch_enable_i(fetch_enable_i),
    .mem_flag_o(mem_flag_o), .mem_result_o(mem_result_o), .instr_addr_o_0(instr_addr_o_0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fib(input int n);
    logic [31:0] a = 0, b = 1, t;
    for (int i = 0; i < n; i++) begin t = a + b; a = b; b = t; end
    return a;
  endfunction

  task automatic preload(input logic [31:0] w1, input logic [31:0] w2);
    for (int i = 0; i < 256; i++) begin
      dut.inst_mem.mem[i] <= (i < prog.size()) ? prog[i] : 32'h0;
      dut.data_mem.mem[i] <= (i == 1) ? w1 : (i == 2) ? w2 : 32'h0;
    end
  endtask

  task automatic start_prog(input logic [31:0] w1, input logic [31:0] w2);
    rst_ni = 1'b0; fetch_enable_i = 1'b0;
    #1 preload(w1, w2);
    #19;
    @(negedge clk);
    rst_ni = 1'b1; fetch_enable_i = 1'b1; t_start = $time;
  endtask

  // Runs until the flag word is nonzero; flags any cycle where the flag is set before the result.
  task automatic run_until_done(input logic [31:0] exp_result, input int budget);
    early = 1'b0; cyc = 0;
    addrs = {instr_addr_o_0};
    while (mem_flag_o == 32'h0 && cyc < budget) begin
      @(negedge clk); cyc++;
      if (instr_addr_o_0 != addrs[$]) addrs.push_back(instr_addr_o_0);
      if (mem_flag_o != 32'h0 && mem_result_o !== exp_result) early = 1'b1;
    end
  endtask

  task automatic check_seq_fetch(input string tag, input int n);
    for (int k = 1; k <= n; k++)
      check($sformatf("%s_addr%0d", tag, k), (k < addrs.size()) ? addrs[k] : 32'hFFFF_FFFF, 32'(4 * k));
  endtask

  initial begin
    // Reset and idle: store program loaded but fetch disabled.
    prog = {32'h02A00293, 32'h00502223, 32'h00100293, 32'h00502023, 32'h0000006F};
    rst_ni = 1'b0; fetch_enable_i = 1'b0;
    #1 preload(32'h0, 32'h0);
    #19;
    check("rst_instr_addr", instr_addr_o_0, 32'h0);
    @(negedge clk); rst_ni = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_instr_addr", instr_addr_o_0, 32'h0);
    check("idle_flag", mem_flag_o, 32'h0);
    check("idle_result", mem_result_o, 32'h0);

    // Store program: result 42 then flag 1.
    fetch_enable_i = 1'b1; t_start = $time;
    run_until_done(32'd42, 100);
    check("store_result", mem_result_o, 32'd42);
    check("store_flag", mem_flag_o, 32'd1);
    check("store_order", {31'b0, early}, 32'h0);
    check("store_in_time", {31'b0, ($time - t_start) < 1000}, 32'h1);
    check_seq_fetch("store", 3);

    // Reset while an instruction read is pending: rvalid dies at once, RAM keeps its data.
    for (int c = 0; c < 10 && !dut.inst_mem.rvalid; c++) @(negedge clk);
    check("rvalid_seen", {31'b0, dut.inst_mem.rvalid}, 32'h1);
    #1 rst_ni = 1'b0;
    #1 check("rvalid_killed", {31'b0, dut.inst_mem.rvalid}, 32'h0);
    check("rst_keeps_result", mem_result_o, 32'd42);
    check("rst_keeps_flag", mem_flag_o, 32'd1);
    check("rst_addr_boot", instr_addr_o_0, 32'h0);

    // Fibonacci loop: a=fib(10) stored to word 1.
    prog = {32'h00000293, 32'h00100313, 32'h00A00393, 32'h00628E33, 32'h00030293,
            32'h000E0313, 32'hFFF38393, 32'hFE0398E3, 32'h00502223, 32'h00100313,
            32'h00602023, 32'h0000006F};
    start_prog(32'h0, 32'h0);
    run_until_done(fib(10), 1000);
    check("fib_result", mem_result_o, fib(10));
    check("fib_flag", mem_flag_o, 32'd1);
    check("fib_order", {31'b0, early}, 32'h0);
    check_seq_fetch("fib", 4);

    // Byte store of 0xAB to byte address 5 over a known word.
    prog = {32'h0AB00293, 32'h005002A3, 32'h00100313, 32'h00602023, 32'h0000006F};
    start_prog(32'h1122_3344, 32'h0);
    run_until_done(32'h1122_AB44, 100);
    check("sb_result", mem_result_o, 32'h1122_AB44);
    check("sb_flag", mem_flag_o, 32'd1);

    // Out-of-range store/load at 0x1008 (aliases word 2 if the decode were wrong).
    prog = {32'h00001337, 32'h05A00293, 32'h00532423, 32'h00832383, 32'h00938393,
            32'h00702223, 32'h00100293, 32'h00502023, 32'h0000006F};
    start_prog(32'h55, 32'hDEAD_BEEF);
    run_until_done(32'd9, 200);
    check("oor_result", mem_result_o, 32'd9);
    check("oor_flag", mem_flag_o, 32'd1);
    check("oor_word2", dut.data_mem.mem[2], 32'hDEAD_BEEF);
    check("oor_lockstep", {31'b0, dut.lockstep_err_q}, 32'h0);

    // Forced divergence on core 1 store data for one cycle.
    prog = {32'h02A00293, 32'h00502223, 32'hFFDFF06F};
    start_prog(32'h0, 32'h0);
    for (int c = 0; c < 50 && mem_result_o != 32'd42; c++) @(negedge clk);
    check("div_pre_result", mem_result_o, 32'd42);
    check("div_pre_lockstep", {31'b0, dut.lockstep_err_q}, 32'h0);
    for (int c = 0; c < 20 && !dut.c0_data_req; c++) @(negedge clk);
    check("div_req_seen", {31'b0, dut.c0_data_req}, 32'h1);
    bad_wdata = dut.c0_data_wdata ^ 32'h0000_0100;
    force dut.c1_data_wdata = bad_wdata;
    @(posedge clk);
    #1 release dut.c1_data_wdata;
    check("div_err_set", {31'b0, dut.lockstep_err_q}, 32'h1);
    repeat (20) @(negedge clk);
    check("div_err_sticky", {31'b0, dut.lockstep_err_q}, 32'h1);
    check("div_result", mem_result_o, 32'd42);
    rst_ni = 1'b0;
    #10 check("div_err_cleared", {31'b0, dut.lockstep_err_q}, 32'h0);
    rst_ni = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
